// File: rtl/ifu_pkg.sv
// Shared IFU definitions: next-PC select encodings, reset PC default,
// queue entry payload and the redirect target function.
package ifu_pkg;

    localparam logic [1:0] NPC_SEL_PC_ADD_4 = 2'b00;
    localparam logic [1:0] NPC_SEL_REG_JMP  = 2'b01;
    localparam logic [1:0] NPC_SEL_J_JMP    = 2'b10;
    localparam logic [1:0] NPC_SEL_BEQ_JMP  = 2'b11;

    localparam logic [31:0] DEFAULT_CODE_SEG_PC = 32'h0000_3000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ifu_entry_t;

    // Redirect target; result is always word aligned.
    function automatic logic [31:0] npc_target(
        input logic [1:0]  sel,
        input logic [31:0] base,
        input logic [31:0] instr,
        input logic [31:0] reg_pc
    );
        logic [31:0] p4;
        logic [31:0] t;
        p4 = base + 32'd4;
        case (sel)
            NPC_SEL_REG_JMP: t = reg_pc;
            NPC_SEL_J_JMP:   t = {p4[31:28], instr[25:0], 2'b00};
            NPC_SEL_BEQ_JMP: t = p4 + {{14{instr[15]}}, instr[15:0], 2'b00};
            default:         t = p4;
        endcase
        return {t[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_im.sv
// Synchronous-read instruction ROM; storage array "im" is loadable
// hierarchically, the write port is tied off in normal use.
module ifu_im #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [31:0]           rd_data,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [31:0]           wr_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0] im [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            im[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= im[rd_addr];
        end
    end

endmodule

// File: rtl/ifu_prefetch.sv
// Prefetching IFU: ROM fetch into a QUEUE_DEPTH-entry queue, valid/ready
// delivery to decode, redirect flush. IFU_FLUSH_CNT_EN adds flush_count.
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] CODE_SEG_PC   = DEFAULT_CODE_SEG_PC,
    parameter int unsigned IM_ADDR_WIDTH = 10,
    parameter int unsigned QUEUE_DEPTH   = 4,
    localparam int unsigned CNT_W        = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect,
    input  logic [1:0]       npc_sel,
    input  logic [31:0]      redirect_base,
    input  logic [31:0]      redirect_instr,
    input  logic [31:0]      reg_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_pc,
    output logic [CNT_W-1:0] queue_count
`ifdef IFU_FLUSH_CNT_EN
    ,
    output logic [15:0]      flush_count
`endif
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);

    logic [31:0]          fetch_pc_q, fetch_pc_d;
    logic [31:0]          inflight_pc_q, inflight_pc_d;
    logic                 inflight_q, inflight_d;
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    ifu_entry_t           q_mem [QUEUE_DEPTH];
    ifu_entry_t           head_entry;

    logic [CNT_W:0]           occupancy;
    logic                     issue;
    logic                     push;
    logic                     pop;
    logic [IM_ADDR_WIDTH-1:0] rom_addr;
    logic [31:0]              rom_data;

    // Issue only reserves a slot counting the in-flight word; pops are not credited.
    assign occupancy = (CNT_W + 1)'(count_q) + (CNT_W + 1)'(inflight_q);
    assign issue     = !reset && !redirect && (occupancy < (CNT_W + 1)'(QUEUE_DEPTH));
    assign push      = inflight_q && !redirect;
    assign pop       = out_valid && out_ready;
    assign rom_addr  = IM_ADDR_WIDTH'((fetch_pc_q - CODE_SEG_PC) >> 2);

    ifu_im #(
        .ADDR_WIDTH (IM_ADDR_WIDTH)
    ) im (
        .clk     (clk),
        .rd_en   (issue),
        .rd_addr (rom_addr),
        .rd_data (rom_data),
        .wr_en   (1'b0),
        .wr_addr ('0),
        .wr_data ('0)
    );

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = 1'b0;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        if (redirect) begin
            fetch_pc_d = npc_target(npc_sel, redirect_base, redirect_instr, reg_pc);
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d    = fetch_pc_q + 32'd4;
                inflight_pc_d = fetch_pc_q;
                inflight_d    = 1'b1;
            end
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= CODE_SEG_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
        end
    end

    // Queue payload storage needs no reset; count gates visibility.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            q_mem[tail_q] <= '{instr: rom_data, pc: inflight_pc_q};
        end
    end

    assign head_entry  = q_mem[head_q];
    assign out_valid   = (count_q != '0);
    assign out_instr   = out_valid ? head_entry.instr : 32'd0;
    assign out_pc      = out_valid ? head_entry.pc : 32'd0;
    assign queue_count = count_q;

`ifdef IFU_FLUSH_CNT_EN
    logic [16:0] flush_sum;

    assign flush_sum = {1'b0, flush_count} + 17'(count_q) + 17'(inflight_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            flush_count <= '0;
        end else if (redirect) begin
            flush_count <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: streaming, backpressure, redirect modes,
// back-to-back redirects and reset priority. Honours IFU_FLUSH_CNT_EN.
module tb_ifu_prefetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [1:0]  npc_sel;
    logic [31:0] redirect_base;
    logic [31:0] redirect_instr;
    logic [31:0] reg_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  queue_count;
`ifdef IFU_FLUSH_CNT_EN
    logic [15:0] flush_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    ifu_prefetch dut (
        .clk            (clk),
        .reset          (reset),
        .redirect       (redirect),
        .npc_sel        (npc_sel),
        .redirect_base  (redirect_base),
        .redirect_instr (redirect_instr),
        .reg_pc         (reg_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .queue_count    (queue_count)
`ifdef IFU_FLUSH_CNT_EN
        ,
        .flush_count    (flush_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input int unsigned idx);
        return (32'(idx) * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic [31:0] rom_at_pc(input logic [31:0] pc);
        logic [31:0] off;
        off = (pc - 32'h0000_3000) >> 2;
        return rom_word(int'(off & 32'h3FF));
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        redirect = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        reset     = 1'b1;
        redirect  = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_vec++;
        if (out_pc !== 32'd0) begin n_err++; $display("FAIL reset_pc: got %h expected 0", out_pc); end
        n_vec++;
        if (out_instr !== 32'd0) begin n_err++; $display("FAIL reset_instr: got %h expected 0", out_instr); end
        n_vec++;
        if (queue_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", queue_count); end
`ifdef IFU_FLUSH_CNT_EN
        n_vec++;
        if (flush_count !== 16'd0) begin n_err++; $display("FAIL reset_flush: got %0d expected 0", flush_count); end
`endif
        reset = 1'b0;
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_lat1: got valid %b expected 0", out_valid); end
        tick();
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_pc !== 32'h3000 + 32'(4 * k)) begin
                n_err++;
                $display("FAIL stream_pc%0d: got v=%b pc=%h expected v=1 pc=%h", k, out_valid, out_pc, 32'h3000 + 32'(4 * k));
            end
            n_vec++;
            if (out_instr !== rom_word(k)) begin
                n_err++;
                $display("FAIL stream_instr%0d: got %h expected %h", k, out_instr, rom_word(k));
            end
            if (k < 2) tick();
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        out_ready = 1'b0;
        repeat (10) tick();
        n_vec++;
        if (queue_count !== 3'd4) begin n_err++; $display("FAIL bp_count: got %0d expected 4", queue_count); end
        n_vec++;
        if (out_pc !== 32'h3000) begin n_err++; $display("FAIL bp_hold_pc: got %h expected 00003000", out_pc); end
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_pc !== 32'h3000 + 32'(4 * k) || out_instr !== rom_word(k)) begin
                n_err++;
                $display("FAIL bp_drain%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                         k, out_valid, out_pc, out_instr, 32'h3000 + 32'(4 * k), rom_word(k));
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_redirect_flush();
        apply_reset();
        out_ready = 1'b0;
        repeat (4) tick();
        n_vec++;
        if (queue_count !== 3'd3) begin n_err++; $display("FAIL rf_pre_count: got %0d expected 3", queue_count); end
        redirect       = 1'b1;
        npc_sel        = 2'b01;
        reg_pc         = 32'h0000_3101;
        redirect_base  = 32'd0;
        redirect_instr = 32'd0;
        tick();
        redirect = 1'b0;
        n_vec++;
        if (queue_count !== 3'd0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rf_flush: got count=%0d v=%b expected count=0 v=0", queue_count, out_valid);
        end
`ifdef IFU_FLUSH_CNT_EN
        n_vec++;
        if (flush_count !== 16'd4) begin n_err++; $display("FAIL rf_flush_count: got %0d expected 4", flush_count); end
`endif
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rf_lat1: got valid %b expected 0", out_valid); end
        tick();
        n_vec++;
        if (out_valid !== 1'b1 || out_pc !== 32'h3100 || out_instr !== rom_word(32'h40)) begin
            n_err++;
            $display("FAIL rf_target: got v=%b pc=%h instr=%h expected v=1 pc=00003100 instr=%h",
                     out_valid, out_pc, out_instr, rom_word(32'h40));
        end
    endtask

    task automatic test_redirect_modes();
        logic [1:0]  t_sel  [6] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b00, 2'b01};
        logic [31:0] t_base [6] = '{32'h3100, 32'h3118, 32'h312C, 32'h311C, 32'h3200, 32'h0};
        logic [31:0] t_ins  [6] = '{32'h0800_0C42, 32'h1000_0003, 32'h1000_FFFB, 32'h1000_FFFF, 32'h0, 32'h0};
        logic [31:0] t_reg  [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_4002};
        logic [31:0] t_exp  [6] = '{32'h3108, 32'h3128, 32'h311C, 32'h311C, 32'h3204, 32'h4000};
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            redirect       = 1'b1;
            npc_sel        = t_sel[i];
            redirect_base  = t_base[i];
            redirect_instr = t_ins[i];
            reg_pc         = t_reg[i];
            tick();
            redirect = 1'b0;
            tick();
            tick();
            n_vec++;
            if (out_valid !== 1'b1 || out_pc !== t_exp[i]) begin
                n_err++;
                $display("FAIL mode%0d_pc: got v=%b pc=%h expected v=1 pc=%h", i, out_valid, out_pc, t_exp[i]);
            end
            n_vec++;
            if (out_instr !== rom_at_pc(t_exp[i])) begin
                n_err++;
                $display("FAIL mode%0d_instr: got %h expected %h", i, out_instr, rom_at_pc(t_exp[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        redirect = 1'b1;
        npc_sel  = 2'b01;
        reg_pc   = 32'h0000_3400;
        tick();
        npc_sel       = 2'b00;
        redirect_base = 32'h0000_3500;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        n_vec++;
        if (out_valid !== 1'b1 || out_pc !== 32'h3504 || out_instr !== rom_word(32'h141)) begin
            n_err++;
            $display("FAIL b2b_last_wins: got v=%b pc=%h instr=%h expected v=1 pc=00003504 instr=%h",
                     out_valid, out_pc, out_instr, rom_word(32'h141));
        end
    endtask

    task automatic test_reset_wins();
        out_ready = 1'b0;
        repeat (8) tick();
        n_vec++;
        if (queue_count !== 3'd4) begin n_err++; $display("FAIL rw_full: got %0d expected 4", queue_count); end
        reset    = 1'b1;
        redirect = 1'b1;
        npc_sel  = 2'b01;
        reg_pc   = 32'h0000_3600;
        tick();
        reset    = 1'b0;
        redirect = 1'b0;
        n_vec++;
        if (queue_count !== 3'd0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rw_cleared: got count=%0d v=%b expected count=0 v=0", queue_count, out_valid);
        end
`ifdef IFU_FLUSH_CNT_EN
        n_vec++;
        if (flush_count !== 16'd0) begin n_err++; $display("FAIL rw_flush: got %0d expected 0", flush_count); end
`endif
        tick();
        tick();
        n_vec++;
        if (out_valid !== 1'b1 || out_pc !== 32'h3000 || out_instr !== rom_word(0)) begin
            n_err++;
            $display("FAIL rw_first: got v=%b pc=%h instr=%h expected v=1 pc=00003000 instr=%h",
                     out_valid, out_pc, out_instr, rom_word(0));
        end
        out_ready = 1'b1;
        tick();
        n_vec++;
        if (out_pc !== 32'h3004) begin n_err++; $display("FAIL rw_second: got %h expected 00003004", out_pc); end
        out_ready = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        redirect       = 1'b0;
        npc_sel        = 2'b00;
        redirect_base  = 32'd0;
        redirect_instr = 32'd0;
        reg_pc         = 32'd0;
        out_ready      = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            dut.im.im[i] = rom_word(i);
        end
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_redirect_modes();
        test_back_to_back();
        test_reset_wins();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
